// File: rtl/fetch_fifo_rvc_if.sv
// ----------------------------------------------------------------------------
// fetch_fifo_rvc_if
// Bundles the two handshakes of the RVC-aware fetch FIFO:
//   in_*  : fetch word from the IMEM fetch port (valid/ready, data, address, error)
//   out_* : re-aligned instruction towards decode (valid/ready, data, PC,
//           compressed flag, error tag)
// Modports:
//   master : the environment (drives the fetch side, consumes instructions)
//   slave  : the FIFO itself
// ----------------------------------------------------------------------------
interface fetch_fifo_rvc_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rdata;
    logic [31:0] in_addr;
    logic        in_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [31:0] out_addr;
    logic        out_compressed;
    logic        out_err;

    modport master (
        output in_valid, in_rdata, in_addr, in_err, out_ready,
        input  in_ready, out_valid, out_rdata, out_addr, out_compressed, out_err
    );

    modport slave (
        input  in_valid, in_rdata, in_addr, in_err, out_ready,
        output in_ready, out_valid, out_rdata, out_addr, out_compressed, out_err
    );
endinterface

// File: rtl/fetch_fifo_rvc.sv
// ----------------------------------------------------------------------------
// fetch_fifo_rvc
// Instruction fetch FIFO that stores 32-bit fetch words as 16-bit halfwords and
// presents whole 16/32-bit RISC-V instructions (RVC aware) to decode, together
// with their PC, a compressed flag and a fetch-error tag.
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset
//   clear_i      flush (redirect); the next push reloads the PC
//   bus          fetch_fifo_rvc_if.slave: fetch-side and decode-side handshakes
//   occupancy_o  number of valid halfwords stored
// Parameters:
//   DEPTH        capacity in 32-bit words (2*DEPTH halfword slots), >= 2
// ----------------------------------------------------------------------------
module fetch_fifo_rvc #(
    parameter int DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clear_i,
    fetch_fifo_rvc_if.slave                bus,
    output logic [$clog2(2*DEPTH+1)-1:0]   occupancy_o
);
    localparam int NSLOT = 2 * DEPTH;
    localparam int OCC_W = $clog2(2 * DEPTH + 1);

    // Halfword queue; slot 0 is the head. Slots at index >= occ_r are stale.
    logic [15:0]      hw_r  [NSLOT];
    logic             err_r [NSLOT];
    logic [OCC_W-1:0] occ_r;
    logic [31:0]      pc_r;
    logic             pc_loaded_r;

    logic             slot0_vld_s;
    logic             slot1_vld_s;
    logic             compressed_s;
    logic             single_s;
    logic             out_valid_s;
    logic             in_ready_s;
    logic             push_s;
    logic             pop_s;
    logic             half_start_s;
    logic [1:0]       push_n_s;
    logic [1:0]       pop_n_s;
    logic [OCC_W-1:0] occ_nxt_s;
    int               base_s;

    // Two zero pad slots so the shift-down can always read i+1 / i+2.
    logic [15:0]      hw_ext_s  [NSLOT+2];
    logic             err_ext_s [NSLOT+2];
    logic [15:0]      hw_sh_s   [NSLOT];
    logic             err_sh_s  [NSLOT];
    logic [15:0]      hw_nxt_s  [NSLOT];
    logic             err_nxt_s [NSLOT];

    assign slot0_vld_s  = (occ_r != OCC_W'(0));
    assign slot1_vld_s  = (occ_r >  OCC_W'(1));
    assign compressed_s = (hw_r[0][1:0] != 2'b11);
    // An errored head is retired alone, never waiting for a second half.
    assign single_s     = compressed_s | err_r[0];

    assign out_valid_s  = ~clear_i & ((slot0_vld_s & compressed_s) |
                                      (slot0_vld_s & slot1_vld_s) |
                                      (slot0_vld_s & err_r[0]));
    // Ready depends on registered occupancy only, never on out_ready.
    assign in_ready_s   = ~clear_i & (occ_r <= OCC_W'(NSLOT - 2));

    assign push_s       = bus.in_valid & in_ready_s & ~clear_i;
    assign pop_s        = out_valid_s & bus.out_ready;
    // First push after reset/clear at a halfword-aligned address skips hw0.
    assign half_start_s = ~pc_loaded_r & bus.in_addr[1];

    assign push_n_s     = push_s ? (half_start_s ? 2'd1 : 2'd2) : 2'd0;
    assign pop_n_s      = pop_s  ? (single_s     ? 2'd1 : 2'd2) : 2'd0;
    assign occ_nxt_s    = occ_r + OCC_W'(push_n_s) - OCC_W'(pop_n_s);
    // Pushed halfwords land right after the survivors of this cycle's pop.
    assign base_s       = int'(occ_r) - int'(pop_n_s);

    assign bus.in_ready       = in_ready_s;
    assign bus.out_valid      = out_valid_s;
    assign bus.out_rdata      = single_s ? {16'h0000, hw_r[0]} : {hw_r[1], hw_r[0]};
    assign bus.out_addr       = pc_r;
    assign bus.out_compressed = compressed_s;
    assign bus.out_err        = single_s ? err_r[0] : (err_r[0] | err_r[1]);
    assign occupancy_o        = occ_r;

    // Padded copy of the queue used as the shift source.
    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            hw_ext_s[i]  = hw_r[i];
            err_ext_s[i] = err_r[i];
        end
        hw_ext_s[NSLOT]    = 16'h0000;
        err_ext_s[NSLOT]   = 1'b0;
        hw_ext_s[NSLOT+1]  = 16'h0000;
        err_ext_s[NSLOT+1] = 1'b0;
    end

    // Next queue contents: shift down by the popped count, then append the push.
    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            case (pop_n_s)
                2'd1: begin
                    hw_sh_s[i]  = hw_ext_s[i+1];
                    err_sh_s[i] = err_ext_s[i+1];
                end
                2'd2: begin
                    hw_sh_s[i]  = hw_ext_s[i+2];
                    err_sh_s[i] = err_ext_s[i+2];
                end
                default: begin
                    hw_sh_s[i]  = hw_ext_s[i];
                    err_sh_s[i] = err_ext_s[i];
                end
            endcase
            if (push_s && (i == base_s)) begin
                hw_nxt_s[i]  = half_start_s ? bus.in_rdata[31:16] : bus.in_rdata[15:0];
                err_nxt_s[i] = bus.in_err;
            end else if (push_s && !half_start_s && (i == base_s + 1)) begin
                hw_nxt_s[i]  = bus.in_rdata[31:16];
                err_nxt_s[i] = bus.in_err;
            end else begin
                hw_nxt_s[i]  = hw_sh_s[i];
                err_nxt_s[i] = err_sh_s[i];
            end
        end
    end

    // Queue, occupancy and PC registers; reset beats clear, clear beats push/pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_r       <= OCC_W'(0);
            pc_r        <= 32'h0000_0000;
            pc_loaded_r <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                hw_r[i]  <= 16'h0000;
                err_r[i] <= 1'b0;
            end
        end else if (clear_i) begin
            occ_r       <= OCC_W'(0);
            pc_r        <= pc_r;
            pc_loaded_r <= 1'b0;
        end else begin
            occ_r <= occ_nxt_s;
            for (int i = 0; i < NSLOT; i++) begin
                hw_r[i]  <= hw_nxt_s[i];
                err_r[i] <= err_nxt_s[i];
            end
            // A pop cannot coincide with the loading push: the queue is empty then.
            if (push_s && !pc_loaded_r) begin
                pc_r <= bus.in_addr;
            end else if (pop_s) begin
                pc_r <= pc_r + (single_s ? 32'd2 : 32'd4);
            end else begin
                pc_r <= pc_r;
            end
            pc_loaded_r <= pc_loaded_r | push_s;
        end
    end
endmodule

// File: tb/tb_fetch_fifo_rvc.sv
// ----------------------------------------------------------------------------
// tb_fetch_fifo_rvc
// Directed self-checking bench for fetch_fifo_rvc (DEPTH=4). Inputs change
// 1 ns after the rising edge and outputs are compared in the same window.
// ----------------------------------------------------------------------------
module tb_fetch_fifo_rvc;
    logic       clk_s;
    logic       rst_s;
    logic       clear_s;
    logic [3:0] occ_s;
    int         n_total_r;
    int         n_pass_r;

    fetch_fifo_rvc_if bus_if ();

    fetch_fifo_rvc #(.DEPTH(4)) dut (
        .clk_i       (clk_s),
        .rst_i       (rst_s),
        .clear_i     (clear_s),
        .bus         (bus_if),
        .occupancy_o (occ_s)
    );

    // 100 MHz clock
    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total_r++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            n_pass_r++;
        end
    endtask

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic push_word(input logic [31:0] data, input logic [31:0] addr, input logic err);
        bus_if.in_valid = 1'b1;
        bus_if.in_rdata = data;
        bus_if.in_addr  = addr;
        bus_if.in_err   = err;
        tick();
        bus_if.in_valid = 1'b0;
        bus_if.in_err   = 1'b0;
        #1;
    endtask

    task automatic pop_one();
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
        #1;
    endtask

    task automatic do_clear();
        clear_s = 1'b1;
        tick();
        clear_s = 1'b0;
        #1;
    endtask

    initial begin
        n_total_r        = 0;
        n_pass_r         = 0;
        rst_s            = 1'b1;
        clear_s          = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_rdata  = 32'h0000_0000;
        bus_if.in_addr   = 32'h0000_0000;
        bus_if.in_err    = 1'b0;
        bus_if.out_ready = 1'b0;
        tick();
        tick();
        rst_s = 1'b0;
        #1;

        // Reset state
        check_eq("rst_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check_eq("rst_ready", {31'd0, bus_if.in_ready}, 32'd1);
        check_eq("rst_occ",   {28'd0, occ_s}, 32'd0);
        check_eq("rst_addr",  bus_if.out_addr, 32'h0000_0000);
        check_eq("rst_err",   {31'd0, bus_if.out_err}, 32'd0);

        // Two compressed instructions in one word
        push_word(32'h0001_4501, 32'h0000_0100, 1'b0);
        check_eq("t1_valid", {31'd0, bus_if.out_valid}, 32'd1);
        check_eq("t1_rdata", bus_if.out_rdata, 32'h0000_4501);
        check_eq("t1_addr",  bus_if.out_addr, 32'h0000_0100);
        check_eq("t1_c",     {31'd0, bus_if.out_compressed}, 32'd1);
        check_eq("t1_occ",   {28'd0, occ_s}, 32'd2);
        pop_one();
        check_eq("t1_rdata2", bus_if.out_rdata, 32'h0000_0001);
        check_eq("t1_addr2",  bus_if.out_addr, 32'h0000_0102);
        check_eq("t1_c2",     {31'd0, bus_if.out_compressed}, 32'd1);
        pop_one();
        check_eq("t1_occ0",   {28'd0, occ_s}, 32'd0);
        check_eq("t1_empty",  {31'd0, bus_if.out_valid}, 32'd0);
        check_eq("t1_pcend",  bus_if.out_addr, 32'h0000_0104);

        // 32-bit instruction split across two fetch words
        do_clear();
        push_word(32'h0513_4501, 32'h0000_0200, 1'b0);
        check_eq("t2_rdata", bus_if.out_rdata, 32'h0000_4501);
        check_eq("t2_addr",  bus_if.out_addr, 32'h0000_0200);
        pop_one();
        check_eq("t2_partial", {31'd0, bus_if.out_valid}, 32'd0);
        check_eq("t2_occ1",    {28'd0, occ_s}, 32'd1);
        push_word(32'h8082_00A0, 32'h0000_0204, 1'b0);
        check_eq("t2_valid32", {31'd0, bus_if.out_valid}, 32'd1);
        check_eq("t2_rdata32", bus_if.out_rdata, 32'h00A0_0513);
        check_eq("t2_addr32",  bus_if.out_addr, 32'h0000_0202);
        check_eq("t2_c32",     {31'd0, bus_if.out_compressed}, 32'd0);
        pop_one();
        check_eq("t2_rdata3", bus_if.out_rdata, 32'h0000_8082);
        check_eq("t2_addr3",  bus_if.out_addr, 32'h0000_0206);
        check_eq("t2_c3",     {31'd0, bus_if.out_compressed}, 32'd1);

        // Halfword-aligned start after a clear
        do_clear();
        push_word(32'h4501_FFFF, 32'h0000_0302, 1'b0);
        check_eq("t3_occ",   {28'd0, occ_s}, 32'd1);
        check_eq("t3_rdata", bus_if.out_rdata, 32'h0000_4501);
        check_eq("t3_addr",  bus_if.out_addr, 32'h0000_0302);
        check_eq("t3_c",     {31'd0, bus_if.out_compressed}, 32'd1);

        // Fill to capacity, dropped push, pop reopens ready
        do_clear();
        push_word(32'h0000_0013, 32'h0000_0600, 1'b0);
        push_word(32'h0040_0093, 32'h0000_0604, 1'b0);
        push_word(32'h0050_0113, 32'h0000_0608, 1'b0);
        check_eq("t4_ready6", {31'd0, bus_if.in_ready}, 32'd1);
        push_word(32'h0060_0193, 32'h0000_060C, 1'b0);
        check_eq("t4_occ8",   {28'd0, occ_s}, 32'd8);
        check_eq("t4_full",   {31'd0, bus_if.in_ready}, 32'd0);
        push_word(32'hDEAD_BEEF, 32'h0000_0610, 1'b0);
        check_eq("t4_drop",   {28'd0, occ_s}, 32'd8);
        check_eq("t4_head",   bus_if.out_rdata, 32'h0000_0013);
        check_eq("t4_hpc",    bus_if.out_addr, 32'h0000_0600);
        pop_one();
        check_eq("t4_occ6",   {28'd0, occ_s}, 32'd6);
        check_eq("t4_ready",  {31'd0, bus_if.in_ready}, 32'd1);
        check_eq("t4_next",   bus_if.out_rdata, 32'h0040_0093);
        check_eq("t4_npc",    bus_if.out_addr, 32'h0000_0604);

        // Clear wins over simultaneous push and pop
        clear_s          = 1'b1;
        bus_if.in_valid  = 1'b1;
        bus_if.in_rdata  = 32'h1234_5678;
        bus_if.in_addr   = 32'h0000_0700;
        bus_if.out_ready = 1'b1;
        #1;
        check_eq("t6_vld_clr", {31'd0, bus_if.out_valid}, 32'd0);
        check_eq("t6_rdy_clr", {31'd0, bus_if.in_ready}, 32'd0);
        tick();
        clear_s          = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        #1;
        check_eq("t6_occ0",  {28'd0, occ_s}, 32'd0);
        check_eq("t6_empty", {31'd0, bus_if.out_valid}, 32'd0);
        push_word(32'h0001_4501, 32'h0000_0500, 1'b0);
        check_eq("t6_pc",    bus_if.out_addr, 32'h0000_0500);
        check_eq("t6_occ2",  {28'd0, occ_s}, 32'd2);

        // Errored uncompressed head retires one halfword
        do_clear();
        push_word(32'hFFFF_FFFF, 32'h0000_0400, 1'b1);
        check_eq("t5_valid", {31'd0, bus_if.out_valid}, 32'd1);
        check_eq("t5_err",   {31'd0, bus_if.out_err}, 32'd1);
        check_eq("t5_rdata", bus_if.out_rdata, 32'h0000_FFFF);
        pop_one();
        check_eq("t5_occ1",  {28'd0, occ_s}, 32'd1);
        check_eq("t5_pc",    bus_if.out_addr, 32'h0000_0402);
        check_eq("t5_err2",  {31'd0, bus_if.out_err}, 32'd1);

        // Reset mid-stream discards content
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        #1;
        check_eq("rst2_occ",  {28'd0, occ_s}, 32'd0);
        check_eq("rst2_vld",  {31'd0, bus_if.out_valid}, 32'd0);
        check_eq("rst2_addr", bus_if.out_addr, 32'h0000_0000);

        // PC wrap from 0xFFFF_FFFE
        push_word(32'h0001_0001, 32'hFFFF_FFFE, 1'b0);
        check_eq("wr_occ",   {28'd0, occ_s}, 32'd1);
        check_eq("wr_addr",  bus_if.out_addr, 32'hFFFF_FFFE);
        check_eq("wr_rdata", bus_if.out_rdata, 32'h0000_0001);
        pop_one();
        check_eq("wr_pc0",   bus_if.out_addr, 32'h0000_0000);
        check_eq("wr_occ0",  {28'd0, occ_s}, 32'd0);

        $display("%0d/%0d checks passed", n_pass_r, n_total_r);
        $finish;
    end
endmodule
